// File: rtl/deadlock_report_arbiter_if.sv
// Report-path bundle between the deadlock monitors, the arbiter and its consumer.
//   mon_block/mon_info/clear : monitor flags, per-monitor info slices, flush pulse
//   rpt_valid/rpt_ready      : report handshake, with rpt_idx/rpt_info as payload
//   any_deadlock             : some monitor is currently at its persistence threshold
//   report_count             : reports handed off, saturating
// master = the side feeding monitors and consuming reports; slave = the arbiter.
interface deadlock_report_arbiter_if #(
   parameter int unsigned NUM_MON = 4,
   parameter int unsigned INFO_W  = 4
);
   localparam int unsigned IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;

   logic [NUM_MON-1:0]        mon_block;
   logic [NUM_MON*INFO_W-1:0] mon_info;
   logic                      clear;
   logic                      rpt_valid;
   logic                      rpt_ready;
   logic [IDX_W-1:0]          rpt_idx;
   logic [INFO_W-1:0]         rpt_info;
   logic                      any_deadlock;
   logic [15:0]               report_count;

   modport master (
      output mon_block, mon_info, clear, rpt_ready,
      input  rpt_valid, rpt_idx, rpt_info, any_deadlock, report_count
   );

   modport slave (
      input  mon_block, mon_info, clear, rpt_ready,
      output rpt_valid, rpt_idx, rpt_info, any_deadlock, report_count
   );
endinterface

// File: rtl/deadlock_report_arbiter.sv
// Persistence-filters NUM_MON deadlock monitor flags and reports each qualified
// episode exactly once, round-robin, on a single valid/ready channel.
//   clock   : rising-edge system clock
//   reset_n : synchronous active-low reset
//   bus     : deadlock_report_arbiter_if slave (monitor inputs, report channel, status)
module deadlock_report_arbiter #(
   parameter int unsigned NUM_MON     = 4,
   parameter int unsigned INFO_W      = 4,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   deadlock_report_arbiter_if.slave   bus
);
   localparam int unsigned IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;
   localparam logic [CNT_W-1:0] HOLD    = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

   state_t              state_q, state_d;
   logic                valid_q, valid_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [INFO_W-1:0]   info_q, info_d;
   logic                handshake;

   logic [CNT_W-1:0]    cnt_q      [NUM_MON];
   logic [INFO_W-1:0]   lat_info_q [NUM_MON];
   logic [NUM_MON-1:0]  pending_q;
   logic [NUM_MON-1:0]  reported_q;
   logic [IDX_W-1:0]    last_grant_q;
   logic                any_q;
   logic [15:0]         count_q;
   logic [15:0]         count_base;

   logic [NUM_MON-1:0]  wipe;
   logic [NUM_MON-1:0]  qualify;
   logic [NUM_MON-1:0]  at_hold;
   logic                grant_found;
   logic [IDX_W-1:0]    grant_idx;

   // Per-monitor qualification; clear spares only the report currently in flight.
   always_comb begin
      wipe    = '0;
      qualify = '0;
      at_hold = '0;
      for (int i = 0; i < int'(NUM_MON); i++) begin
         wipe[i]    = bus.clear && !((state_q == ST_SEND) && (idx_q == IDX_W'(i)));
         at_hold[i] = (cnt_q[i] == HOLD);
         qualify[i] = bus.mon_block[i] && (cnt_q[i] == HOLD_M1) &&
                      !reported_q[i] && !pending_q[i] && !wipe[i];
      end
   end

   // Round-robin pick: first pending index after last_grant, wrapping.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand        = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int unsigned k = 1; k <= NUM_MON; k++) begin
         cand = IDX_W'((32'(last_grant_q) + k) % NUM_MON);
         if (!grant_found && pending_q[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Report FSM: next state and next registered report outputs.
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      info_d    = info_q;
      handshake = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               valid_d = 1'b1;
               idx_d   = grant_idx;
               info_d  = lat_info_q[grant_idx];
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (valid_q && bus.rpt_ready) begin
               handshake = 1'b1;
               valid_d   = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A clear in the same cycle as a handshake restarts the count at 1.
   always_comb begin
      count_base = bus.clear ? 16'h0000 : count_q;
   end

   // FSM state and report output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         idx_q   <= '0;
         info_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         info_q  <= info_d;
      end
   end

   // Persistence counters, pending/reported flags, latched info and status.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_MON); i++) begin
            cnt_q[i]      <= '0;
            lat_info_q[i] <= '0;
         end
         pending_q    <= '0;
         reported_q   <= '0;
         last_grant_q <= IDX_W'(NUM_MON - 1);
         any_q        <= 1'b0;
         count_q      <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_MON); i++) begin
            if (wipe[i] || !bus.mon_block[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] != HOLD) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end

            // Handshake sets reported even if the monitor already dropped;
            // the next low sample rearms it.
            if (handshake && (idx_q == IDX_W'(i))) begin
               pending_q[i]  <= 1'b0;
               reported_q[i] <= 1'b1;
            end else if (wipe[i]) begin
               pending_q[i]  <= 1'b0;
               reported_q[i] <= 1'b0;
            end else begin
               if (!bus.mon_block[i]) begin
                  reported_q[i] <= 1'b0;
               end
               if (qualify[i]) begin
                  pending_q[i]  <= 1'b1;
                  lat_info_q[i] <= bus.mon_info[i*INFO_W +: INFO_W];
               end
            end
         end

         if (handshake) begin
            last_grant_q <= idx_q;
            count_q      <= (count_base == 16'hFFFF) ? 16'hFFFF : count_base + 16'd1;
         end else begin
            count_q      <= count_base;
         end

         any_q <= |at_hold;
      end
   end

   assign bus.rpt_valid    = valid_q;
   assign bus.rpt_idx      = idx_q;
   assign bus.rpt_info     = info_q;
   assign bus.any_deadlock = any_q;
   assign bus.report_count = count_q;

endmodule

// File: doc/deadlock_report_arbiter.md
Name: deadlock_report_arbiter

Overview:
- Collects `block`/`axis_block_info` outputs from NUM_MON per-dataflow deadlock monitors in the packet handler and qualifies each one with a persistence filter.
- Arbitrates qualified deadlock events round-robin onto a single valid/ready report channel. Each event is reported exactly once per episode.
- Sits between the HLS deadlock monitors and the debug/status path (CSR capture or host-visible log FIFO).

Parameters:
- NUM_MON, 4, number of monitor inputs (>=2).
- INFO_W, 4, width of each monitor's axis_block_info field.
- HOLD_CYCLES, 16, consecutive cycles block must be high before an event qualifies (>=1, <=2^CNT_W-1).
- CNT_W, 8, width of per-monitor persistence counter.
- IDX_W, max(1,clog2(NUM_MON)), width of report index (derived, do not override).

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  synchronous active-low reset.
- mon_block  in  NUM_MON  per-monitor block flag, bit i = monitor i.
- mon_info  in  NUM_MON*INFO_W  per-monitor axis_block_info, slice [i*INFO_W +: INFO_W].
- clear  in  1  single-cycle pulse: flush all pending/rearm state and zero report_count.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts report.
- rpt_idx  out  IDX_W  index of reporting monitor.
- rpt_info  out  INFO_W  info latched at qualification.
- any_deadlock  out  1  OR over monitors whose counter is at threshold.
- report_count  out  16  reports handed off, saturating at 16'hFFFF.

Behaviour:
- Reset (reset_n=0 at an edge): all counters, pending, reported and latched info cleared; FSM to IDLE; last_grant=NUM_MON-1. rpt_valid, rpt_idx, rpt_info, any_deadlock and report_count all 0. This applies mid-handshake: an in-flight report is dropped.
- Per-monitor persistence, monitor i:
  - mon_block[i]=0: cnt[i] <= 0 and reported[i] <= 0 (rearm).
  - mon_block[i]=1: cnt[i] increments, saturating at HOLD_CYCLES.
  - Qualify cycle: mon_block[i]=1 and cnt[i]==HOLD_CYCLES-1 and reported[i]=0 and pending[i]=0. At that edge, pending[i] <= 1 and info[i] <= mon_info slice i.
  - Net effect: pending rises on the HOLD_CYCLES-th consecutive high sample.
- any_deadlock is a registered OR of (cnt[i]==HOLD_CYCLES) across monitors. It is independent of reporting.
- A monitor that stays blocked after being reported produces no further report until it deasserts for at least 1 cycle and requalifies.
- FSM, two states:
  - IDLE: if any pending, grant the first pending index scanning upward from last_grant+1 with wrap. At the edge, load rpt_idx and rpt_info from info[grant], set rpt_valid=1, go SEND. Otherwise stay.
  - SEND: rpt_valid, rpt_idx and rpt_info are held stable until rpt_valid & rpt_ready. On that edge:
    - pending[idx] <= 0, reported[idx] <= 1, last_grant <= idx;
    - report_count increments, saturating;
    - rpt_valid <= 0, return to IDLE.
- Throughput: at most one report per 2 cycles; rpt_valid is low for at least 1 cycle between reports.
- Latency: block first sampled high at edge N gives pending at edge N+HOLD_CYCLES-1 and rpt_valid at edge N+HOLD_CYCLES.
- Changes to mon_info after qualification do not affect a latched or in-flight report.
- clear pulse:
  - Zeroes cnt, pending, reported and report_count for all monitors except the in-flight index during SEND.
  - The in-flight report completes normally and still increments report_count from 0.
  - clear and a qualify event in the same cycle: clear wins.
- A new qualification for another monitor during SEND is accepted and queued in pending.
- mon_block deasserting while its report is in SEND: the report still completes. reported is set at the handshake, then cleared on the next cycle the block is sampled low.

Test Plan:
- HOLD_CYCLES=16: mon_block[2] high 15 cycles then low -> rpt_valid stays 0, any_deadlock stays 0, report_count=0.
- mon_block[1] high continuously from edge 0 with info 4'hD, rpt_ready=1 -> rpt_valid at edge 16 with rpt_idx=1, rpt_info=4'hD, handshake at edge 17, report_count=1, no further reports. Then drop 1 cycle, reassert 16 cycles -> second report, report_count=2.
- Monitors 0, 2, 3 qualify on the same edge, rpt_ready=1 -> reports idx 0, 2, 3 on consecutive 2-cycle slots. Then monitor 0 requalifies alongside 1 -> order 0, then 1 (scan starts at 0 after last_grant=3).
- rpt_ready=0 for 10 cycles during SEND while mon_info[idx] toggles -> rpt_valid, rpt_idx and rpt_info stable. Handshake on ready=1, report_count +1.
- clear during SEND of idx 3 with idx 0 pending -> idx 3 report completes, report_count=1, idx 0 is not reported until it requalifies.
- reset_n=0 for 1 cycle mid-SEND -> next edge rpt_valid=0 and report_count=0. Everything stays idle until monitors requalify after HOLD_CYCLES.
